// File: rtl/counter_pkg.sv
// Shared types and limits for the counter-sharing arbiter and its picker.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;
  // Supported requester range is 2..NUM_REQ_MAX; indices are sized for the maximum.
  localparam int NUM_REQ_MAX     = 8;
  localparam int IDX_W           = $clog2(NUM_REQ_MAX);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping back to index 0. Produces a one-hot pick and a valid flag.
module rr_pick
  import counter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
    pick  = '0;
    valid = 1'b0;
    // Upper pass covers last+1..NUM_REQ-1, lower pass wraps to 0..last.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i > int'(last))) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i <= int'(last))) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters;
// each granted run counts 0..len-1 and ends with a one-cycle done pulse.
module counter_share_arbiter
  import counter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         count
);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     term_q, term_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [NUM_REQ-1:0]   pick;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [WIDTH-1:0]     pick_term;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Terminal count is len-1 modulo 2^WIDTH, so len==0 naturally yields 2^WIDTH-1.
  always_comb begin
    pick_idx  = '0;
    pick_term = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = IDX_W'(i);
        pick_term = len[i*WIDTH +: WIDTH] - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    count_d  = count_q;
    term_d   = term_q;
    winner_d = winner_q;
    last_d   = last_q;

    unique case (state_q)
      IDLE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (pick_valid) begin
          state_d  = COUNT;
          gnt_d    = pick;
          busy_d   = 1'b1;
          winner_d = pick_idx;
          term_d   = pick_term;
        end
      end

      COUNT: begin
        // gnt_q is one-hot on the winner, so this tests req[winner].
        if ((req & gnt_q) == '0) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
          last_d  = winner_q;
        end else if (count_q == term_q) begin
          state_d = DONE;
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
        last_d  = winner_q;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is only seen at a rising edge and overrides every other update.
    if (!resetb) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      count_q  <= '0;
      term_q   <= '0;
      winner_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      term_q   <= term_d;
      winner_q <= winner_d;
      last_q   <= last_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a transaction-level model of owner / elapsed counts / done.
module tb_counter_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk = 1'b0;
  logic                     resetb;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         count;

  counter_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .req    (req),
    .len    (len),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .count  (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the counter, how many counts elapsed, run length.
  int m_owner = -1;
  int m_k     = 0;
  int m_len   = 0;
  int m_done  = -1;
  int m_last  = NUM_REQ - 1;

  always @(posedge clk) begin
    if (!resetb) begin
      m_owner = -1;
      m_done  = -1;
      m_last  = NUM_REQ - 1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (m_k == m_len - 1) begin
        m_done  = m_owner;
        m_owner = -1;
      end else begin
        m_k++;
      end
    end else if (m_done >= 0) begin
      m_last = m_done;
      m_done = -1;
    end else begin
      bit found;
      found = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
        int i;
        i = (m_last + off) % NUM_REQ;
        if (!found && req[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_k     = 0;
          m_len   = int'(len[i*WIDTH +: WIDTH]);
          if (m_len == 0) m_len = 1 << WIDTH;
        end
      end
    end
  end

  // Observation and requester-behaviour state.
  logic [NUM_REQ-1:0] prev_gnt   = '0;
  logic [NUM_REQ-1:0] raise_pend = '0;
  int                 run_cnt    = 0;
  int                 last_run_cycles = 0;
  int                 max_count  = 0;
  int                 grant_log[$];
  int                 done_hist[NUM_REQ];
  int                 quota[NUM_REQ];

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_len(input int i, input int v);
    len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  // One clock: compare at the falling edge, then apply requester behaviour.
  task automatic step();
    logic [31:0] exp_gnt, exp_done, exp_count;
    @(negedge clk);
    exp_gnt   = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    exp_done  = (m_done  >= 0) ? (32'd1 << m_done)  : 32'd0;
    exp_count = (m_owner >= 0) ? 32'(m_k) : 32'd0;
    check("gnt",   32'(gnt),   exp_gnt);
    check("busy",  32'(busy),  32'(m_owner >= 0));
    check("count", 32'(count), exp_count);
    check("done",  32'(done),  exp_done);

    if (gnt != '0) begin
      if (prev_gnt == '0) begin
        grant_log.push_back(onehot_idx(gnt));
        run_cnt = 0;
      end
      run_cnt++;
      if (int'(count) > max_count) max_count = int'(count);
    end else if (prev_gnt != '0) begin
      last_run_cycles = run_cnt;
    end
    for (int i = 0; i < NUM_REQ; i++) if (done[i]) done_hist[i]++;
    prev_gnt = gnt;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (raise_pend[i]) begin
        req[i]        = 1'b1;
        raise_pend[i] = 1'b0;
      end
    end
    if (m_done >= 0) begin
      req[m_done] = 1'b0;
      if (quota[m_done] > 0) begin
        quota[m_done]--;
        raise_pend[m_done] = 1'b1;
      end
    end
  endtask

  task automatic wait_quiet(input string tag, input int bound);
    bit q;
    q = 1'b0;
    for (int c = 0; c < bound && !q; c++) begin
      step();
      if (req == '0 && raise_pend == '0 && m_owner < 0 && m_done < 0) q = 1'b1;
    end
    check(tag, 32'(q), 32'd1);
  endtask

  task automatic do_reset(input int n);
    resetb = 1'b0;
    repeat (n) step();
    resetb = 1'b1;
  endtask

  initial begin
    int exp_fair[4];
    int exp_alt[4];
    int done1_before;
    bit found;

    resetb = 1'b0;
    req    = '0;
    len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      done_hist[i] = 0;
      quota[i]     = 0;
    end

    // Reset, then a single run of length 5 on requester 0.
    do_reset(2);
    set_len(0, 5);
    req = 4'b0001;
    wait_quiet("single_quiet", 40);
    check("single_run_cycles", 32'(last_run_cycles), 32'd5);
    check("single_max_count", 32'(max_count), 32'd4);

    // Fairness from fresh reset: all four request, length 2 each.
    do_reset(1);
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 2);
    grant_log.delete();
    req = 4'b1111;
    wait_quiet("fair_quiet", 100);
    exp_fair = '{0, 1, 2, 3};
    check("fair_log_size", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_order%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_fair[i]));

    // Requesters 0 and 3 each re-raise once after done.
    grant_log.delete();
    quota[0] = 1;
    quota[3] = 1;
    req = 4'b1001;
    wait_quiet("alt_quiet", 100);
    exp_alt = '{0, 3, 0, 3};
    check("alt_log_size", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_order%0d", i), 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(exp_alt[i]));

    // Length 0 runs the full 256 counts.
    max_count = 0;
    set_len(2, 0);
    req = 4'b0100;
    wait_quiet("len0_quiet", 400);
    check("len0_run_cycles", 32'(last_run_cycles), 32'd256);
    check("len0_max_count", 32'(max_count), 32'd255);

    // Abort: requester 1 drops req at count 3; next pick searches from 2.
    set_len(1, 10);
    req = 4'b0010;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (m_owner == 1 && m_k == 3) found = 1'b1;
    end
    check("abort_reach", 32'(found), 32'd1);
    done1_before = done_hist[1];
    grant_log.delete();
    req = 4'b1001;
    step();
    check("abort_gnt_idle", 32'(gnt), 32'd0);
    check("abort_count_zero", 32'(count), 32'd0);
    wait_quiet("abort_quiet", 100);
    check("abort_no_done", 32'(done_hist[1]), 32'(done1_before));
    check("abort_next_pick", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd3);

    // Reset in the middle of a run at count 7.
    set_len(0, 20);
    req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (m_owner == 0 && m_k == 7) found = 1'b1;
    end
    check("rst_mid_reach", 32'(found), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 3);
    req    = 4'b1111;
    resetb = 1'b0;
    step();
    check("rst_mid_gnt", 32'(gnt), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    grant_log.delete();
    resetb = 1'b1;
    wait_quiet("rst_mid_quiet", 100);
    check("rst_mid_first_pick", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Length change mid-run is ignored.
    set_len(0, 4);
    req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (m_owner == 0 && m_k == 1) found = 1'b1;
    end
    check("lenchg_reach", 32'(found), 32'd1);
    set_len(0, 9);
    wait_quiet("lenchg_quiet", 40);
    check("lenchg_run_cycles", 32'(last_run_cycles), 32'd4);

    // Length 1: single grant cycle.
    set_len(0, 1);
    req = 4'b0001;
    wait_quiet("len1_quiet", 20);
    check("len1_run_cycles", 32'(last_run_cycles), 32'd1);

    // Random traffic: raises, occasional aborts, length churn, rare resets.
    for (int c = 0; c < 1500; c++) begin
      step();
      resetb = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 7) == 0)
          set_len(i, ($urandom_range(0, 59) == 0) ? 0 : int'($urandom_range(1, 6)));
      end
    end
    resetb = 1'b1;
    req    = '0;
    wait_quiet("final_quiet", 400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
